// File: rtl/vec_fmul_seq.sv
// Issue/collect sequencer for a lane's single-precision multiplier: issues one element pair per
// cycle to fpmul, captures each registered result a cycle later and packs the result vector.
module vec_fmul_seq #(
  parameter int unsigned VLEN = 8,
  parameter int unsigned DW   = 32,
  parameter int unsigned IW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IW:0]          vl,
  input  logic [VLEN*DW-1:0]   va,
  input  logic [VLEN*DW-1:0]   vb,
  input  logic                 hold,
  output logic                 mul_en,
  output logic [DW-1:0]        mul_a,
  output logic [DW-1:0]        mul_b,
  input  logic [DW-1:0]        mul_z,
  output logic                 busy,
  output logic                 done,
  output logic [VLEN*DW-1:0]   res
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  localparam logic [IW:0] VlMax = (IW+1)'(VLEN);

  state_e                state_q, state_d;
  logic [VLEN*DW-1:0]    va_q, vb_q, res_q;
  logic [IW:0]           vl_q;
  logic [IW-1:0]         idx_q;
  logic                  cap_v_q;
  logic [IW-1:0]         cap_idx_q;
  logic                  zf_q;
  logic                  sgn_q;

  logic [IW:0]           vl_eff;
  logic                  accept;
  logic                  issue;
  logic                  last;
  logic [DW-1:0]         cur_a, cur_b;

  assign vl_eff = (vl > VlMax) ? VlMax : vl;
  assign accept = (state_q == StIdle) && start;
  assign issue  = (state_q == StIssue) && !hold;
  assign last   = ({1'b0, idx_q} == (vl_q - (IW+1)'(1)));
  assign cur_a  = va_q[idx_q*DW +: DW];
  assign cur_b  = vb_q[idx_q*DW +: DW];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (vl_eff == '0) ? StDone : StIssue;
      end
      StIssue: begin
        if (issue && last) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    mul_en = issue;
    mul_a  = '0;
    mul_b  = '0;
    if (state_q == StIssue) begin
      mul_a = cur_a;
      mul_b = cur_b;
    end
    busy = (state_q == StIssue) || (state_q == StDrain);
    done = (state_q == StDone);
  end

  // Operand latch, issue index and capture pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      va_q      <= '0;
      vb_q      <= '0;
      vl_q      <= '0;
      idx_q     <= '0;
      cap_v_q   <= 1'b0;
      cap_idx_q <= '0;
      zf_q      <= 1'b0;
      sgn_q     <= 1'b0;
      res_q     <= '0;
    end else begin
      cap_v_q <= issue;
      if (issue) begin
        idx_q     <= idx_q + 1'b1;
        cap_idx_q <= idx_q;
        zf_q      <= (cur_a[DW-2:DW-9] == '0) || (cur_b[DW-2:DW-9] == '0);
        sgn_q     <= cur_a[DW-1] ^ cur_b[DW-1];
      end
      // fpmul has no zero path, so zero-exponent operands bypass it with a signed zero
      if (cap_v_q) begin
        res_q[cap_idx_q*DW +: DW] <= zf_q ? {sgn_q, {(DW-1){1'b0}}} : mul_z;
      end
      if (accept) begin
        va_q  <= va;
        vb_q  <= vb;
        vl_q  <= vl_eff;
        idx_q <= '0;
        res_q <= '0;
      end
    end
  end

  assign res = res_q;

endmodule

// File: tb/tb_vec_fmul_seq.sv
// Bench for vec_fmul_seq: stand-in fpmul with one register stage, scoreboard of expected
// result vectors and issued operand pairs, and directed plus random scenarios.
module tb_vec_fmul_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   vl;
  logic [255:0] va, vb;
  logic         hold;
  logic         mul_en;
  logic [31:0]  mul_a, mul_b;
  logic [31:0]  mul_z = '0;
  logic         busy, done;
  logic [255:0] res;

  int n_vec = 0;
  int n_err = 0;

  logic [255:0] sb[$];
  logic [31:0]  pq_a[$], pq_b[$];

  vec_fmul_seq #(.VLEN(8), .DW(32), .IW(3)) dut (
    .clk(clk), .rst(rst), .start(start), .vl(vl), .va(va), .vb(vb), .hold(hold),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .busy(busy), .done(done), .res(res)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: exact for the directed operands, otherwise a distinct per-pair value
  function automatic logic [31:0] fpmul_stub(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (a == 32'h3FC0_0000 && b == 32'h3FC0_0000) return 32'h4010_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] exp_elem(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'b0};
    return fpmul_stub(a, b);
  endfunction

  always @(posedge clk) if (mul_en) mul_z <= fpmul_stub(mul_a, mul_b);

  // Drives one op, checks each issued pair against the pair queue, and reports timing.
  task automatic run_op(input int v, input logic [255:0] a, input logic [255:0] b,
                        input logic [63:0] hmask, input int restart_cyc,
                        output int done_cyc, output int en_cnt, output bit busy_seen,
                        output logic [255:0] r);
    int veff;
    logic [255:0] e;
    logic [31:0] ea, eb;
    veff = (v > 8) ? 8 : v;
    pq_a.delete();
    pq_b.delete();
    e = '0;
    for (int i = 0; i < veff; i++) begin
      pq_a.push_back(a[i*32 +: 32]);
      pq_b.push_back(b[i*32 +: 32]);
      e[i*32 +: 32] = exp_elem(a[i*32 +: 32], b[i*32 +: 32]);
    end
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; vl = v[3:0]; va = a; vb = b; hold = 1'b0;
    done_cyc = -1; en_cnt = 0; busy_seen = 0; r = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == restart_cyc);
      va = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      vb = ~va;
      hold = hmask[c];
      #1;
      if (mul_en) begin
        en_cnt++;
        n_vec++;
        if (pq_a.size() == 0) begin
          n_err++;
          $display("FAIL issue_extra: cycle %0d mul_a=%h mul_b=%h, no issue expected", c,
                   mul_a, mul_b);
        end else begin
          ea = pq_a.pop_front();
          eb = pq_b.pop_front();
          if (mul_a !== ea || mul_b !== eb) begin
            n_err++;
            $display("FAIL issue_pair: cycle %0d got %h*%h, expected %h*%h", c, mul_a, mul_b,
                     ea, eb);
          end
        end
      end
      if (busy) busy_seen = 1;
      if (done) begin
        done_cyc = c;
        r = res;
        break;
      end
    end
    start = 1'b0;
    hold = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0)   begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    n_vec++; if (mul_en !== 1'b0) begin n_err++; $display("FAIL rst_en: got %b want 0", mul_en); end
    n_vec++; if (mul_a !== '0 || mul_b !== '0) begin
      n_err++; $display("FAIL rst_ops: got %h/%h want 0", mul_a, mul_b);
    end
    n_vec++; if (res !== '0) begin n_err++; $display("FAIL rst_res: got %h want 0", res); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic;
    int dc, ec; bit bs; logic [255:0] r, e;
    run_op(4, {8{32'h4000_0000}}, {8{32'h4040_0000}}, '0, 0, dc, ec, bs, r);
    e = sb.pop_front();
    n_vec++; if (dc !== 6) begin n_err++; $display("FAIL basic_done_cyc: got %0d want 6", dc); end
    n_vec++; if (ec !== 4) begin n_err++; $display("FAIL basic_issues: got %0d want 4", ec); end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (r[i*32 +: 32] !== e[i*32 +: 32]) begin
        n_err++; $display("FAIL basic_res[%0d]: got %h want %h", i, r[i*32 +: 32], e[i*32 +: 32]);
      end
    end
  endtask

  task automatic test_zero;
    int dc, ec; bit bs; logic [255:0] r, e;
    run_op(1, {8{32'h0000_0000}}, {8{32'hC000_0000}}, '0, 0, dc, ec, bs, r);
    e = sb.pop_front();
    n_vec++; if (dc !== 3) begin n_err++; $display("FAIL zero_done_cyc: got %0d want 3", dc); end
    n_vec++; if (ec !== 1) begin n_err++; $display("FAIL zero_issues: got %0d want 1", ec); end
    n_vec++; if (r[31:0] !== 32'h8000_0000) begin
      n_err++; $display("FAIL zero_res0: got %h want 80000000", r[31:0]);
    end
    for (int i = 1; i < 8; i++) begin
      n_vec++;
      if (r[i*32 +: 32] !== e[i*32 +: 32]) begin
        n_err++; $display("FAIL zero_res[%0d]: got %h want %h", i, r[i*32 +: 32], e[i*32 +: 32]);
      end
    end
  endtask

  task automatic test_hold;
    int dc, ec; bit bs; logic [255:0] r, e;
    run_op(8, {8{32'h3FC0_0000}}, {8{32'h3FC0_0000}}, 64'h0C, 0, dc, ec, bs, r);
    e = sb.pop_front();
    n_vec++; if (dc !== 12) begin n_err++; $display("FAIL hold_done_cyc: got %0d want 12", dc); end
    n_vec++; if (ec !== 8) begin n_err++; $display("FAIL hold_issues: got %0d want 8", ec); end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (r[i*32 +: 32] !== e[i*32 +: 32]) begin
        n_err++; $display("FAIL hold_res[%0d]: got %h want %h", i, r[i*32 +: 32], e[i*32 +: 32]);
      end
    end
    @(negedge clk); #1;
    n_vec++; if (res !== e) begin n_err++; $display("FAIL hold_res_keep: got %h want %h", res, e); end
  endtask

  task automatic test_clamp;
    int dc, ec; bit bs; logic [255:0] r, e, a, b;
    run_op(0, {8{32'h4000_0000}}, {8{32'h4040_0000}}, '0, 0, dc, ec, bs, r);
    e = sb.pop_front();
    n_vec++; if (dc !== 1) begin n_err++; $display("FAIL vl0_done_cyc: got %0d want 1", dc); end
    n_vec++; if (bs !== 1'b0) begin n_err++; $display("FAIL vl0_busy: got %b want 0", bs); end
    n_vec++; if (r !== e) begin n_err++; $display("FAIL vl0_res: got %h want %h", r, e); end
    for (int i = 0; i < 8; i++) begin
      a[i*32 +: 32] = 32'h4100_0000 + 32'(i);
      b[i*32 +: 32] = 32'h4200_0000 + 32'(i << 4);
    end
    run_op(12, a, b, '0, 0, dc, ec, bs, r);
    e = sb.pop_front();
    n_vec++; if (dc !== 10) begin n_err++; $display("FAIL vl12_done_cyc: got %0d want 10", dc); end
    n_vec++; if (ec !== 8) begin n_err++; $display("FAIL vl12_issues: got %0d want 8", ec); end
    n_vec++; if (r !== e) begin n_err++; $display("FAIL vl12_res: got %h want %h", r, e); end
  endtask

  task automatic test_restart;
    int dc, ec; bit bs; logic [255:0] r, e, a, b;
    for (int i = 0; i < 8; i++) begin
      a[i*32 +: 32] = 32'h3F80_0000 | 32'($urandom_range(0, 32'h7F_FFFF));
      b[i*32 +: 32] = 32'hC080_0000 | 32'($urandom_range(0, 32'h7F_FFFF));
    end
    run_op(8, a, b, '0, 3, dc, ec, bs, r);
    e = sb.pop_front();
    n_vec++; if (dc !== 10) begin n_err++; $display("FAIL restart_done_cyc: got %0d want 10", dc); end
    n_vec++; if (r !== e) begin n_err++; $display("FAIL restart_res: got %h want %h", r, e); end
  endtask

  task automatic test_reset_mid;
    int dc, ec; bit bs, seen; logic [255:0] r, e, a, b;
    @(negedge clk);
    start = 1'b1; vl = 4'd8; va = {8{32'h4000_0000}}; vb = {8{32'h4040_0000}};
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_vec++; if (res !== '0) begin n_err++; $display("FAIL midrst_res: got %h want 0", res); end
    @(negedge clk); rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    n_vec++; if (seen) begin n_err++; $display("FAIL midrst_done: got pulse want none"); end
    for (int i = 0; i < 8; i++) begin
      a[i*32 +: 32] = $urandom | 32'h0080_0000;
      b[i*32 +: 32] = $urandom | 32'h0100_0000;
    end
    run_op(3, a, b, '0, 0, dc, ec, bs, r);
    e = sb.pop_front();
    n_vec++; if (dc !== 5) begin n_err++; $display("FAIL midrst_after_cyc: got %0d want 5", dc); end
    n_vec++; if (r !== e) begin n_err++; $display("FAIL midrst_after_res: got %h want %h", r, e); end
  endtask

  task automatic test_random;
    int dc, ec, v, veff, holds, issued, c; bit bs; logic [255:0] r, e, a, b; logic [63:0] hm;
    for (int k = 0; k < 6; k++) begin
      v = $urandom_range(1, 9);
      veff = (v > 8) ? 8 : v;
      for (int i = 0; i < 8; i++) begin
        a[i*32 +: 32] = $urandom;
        b[i*32 +: 32] = $urandom;
        if ($urandom_range(0, 3) == 0) a[i*32 + 23 +: 8] = 8'd0;
        if ($urandom_range(0, 3) == 0) b[i*32 + 23 +: 8] = 8'd0;
      end
      hm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      holds = 0; issued = 0; c = 1;
      while (issued < veff) begin
        if (hm[c]) holds++; else issued++;
        c++;
      end
      run_op(v, a, b, hm, 0, dc, ec, bs, r);
      e = sb.pop_front();
      n_vec++; if (dc !== veff + 2 + holds) begin
        n_err++; $display("FAIL rand%0d_done_cyc: got %0d want %0d", k, dc, veff + 2 + holds);
      end
      n_vec++; if (ec !== veff) begin
        n_err++; $display("FAIL rand%0d_issues: got %0d want %0d", k, ec, veff);
      end
      n_vec++; if (r !== e) begin n_err++; $display("FAIL rand%0d_res: got %h want %h", k, r, e); end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; vl = '0; va = '0; vb = '0; hold = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    test_basic;
    test_zero;
    test_hold;
    test_clamp;
    test_restart;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
